// File: rtl/csa_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csa_accum_pkg
//  Description : Shared types and width helpers for the carry-save
//                multi-operand accumulator (csa_accum_ctrl, csa_row).
//  Revision    : 1.0  initial release
// ============================================================================
package csa_accum_pkg;

    // Sequencer states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Accumulator width: operand width plus guard bits for headroom
    function automatic int acc_width(input int data_w, input int guard_w);
        return data_w + guard_w;
    endfunction

    // Operand counter width: one bit beyond the guard so 2**guard_w+1 is visible
    function automatic int cnt_width(input int guard_w);
        return guard_w + 1;
    endfunction

endpackage : csa_accum_pkg
`default_nettype wire

// File: rtl/csa_row.sv
`default_nettype none
// ============================================================================
//  Module      : csa_row
//  Description : Purely combinational 3:2 carry-save compressor row.
//                carry_o is already shifted up one place (truncated to
//                WIDTH), so it can be stored at its final weight.
//  Revision    : 1.0  initial release
// ============================================================================
module csa_row #(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] carry_o
);

    // Only the majority bits that survive the shift are computed; the MSB
    // carry falls off the top of the modulo-2**WIDTH result.
    logic [WIDTH-2:0] maj_lo;

    // Bitwise sum and pre-shifted majority carry
    always_comb begin
        sum_o   = a_i ^ b_i ^ c_i;
        maj_lo  = (a_i[WIDTH-2:0] & b_i[WIDTH-2:0])
                | (a_i[WIDTH-2:0] & c_i[WIDTH-2:0])
                | (b_i[WIDTH-2:0] & c_i[WIDTH-2:0]);
        carry_o = {maj_lo, 1'b0};
    end

endmodule : csa_row
`default_nettype wire

// File: rtl/csa_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : csa_accum_ctrl
//  Description : Multi-operand adder sequencer. Operands are compressed one
//                per cycle into redundant sum/carry registers; the last
//                operand triggers a single carry-propagate resolve and the
//                binary result is offered on an output handshake.
//  Options     : CSA_ACC_SAT_EN - saturate out_sum to all-ones on overflow
//                (default build wraps modulo 2**ACC_W).
//  Revision    : 1.0  initial release
// ============================================================================
module csa_accum_ctrl
    import csa_accum_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int GUARD_W = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_W-1:0]                     in_data,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [acc_width(DATA_W, GUARD_W)-1:0] out_sum,
    output logic [cnt_width(GUARD_W)-1:0]         out_count,
    output logic                                  out_ovf,
    output logic                                  busy
);

    localparam int ACC_W = acc_width(DATA_W, GUARD_W);
    localparam int CNT_W = cnt_width(GUARD_W);
    // Count at which one more accepted operand exceeds the guard headroom
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(1) << GUARD_W;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   s_q, s_d;
    logic [ACC_W-1:0]   c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               oovf_q, oovf_d;

    logic [ACC_W-1:0]   operand;
    logic [ACC_W-1:0]   row_sum;
    logic [ACC_W-1:0]   row_carry;
    logic [ACC_W-1:0]   resolved;

    assign operand = {{GUARD_W{1'b0}}, in_data};

    csa_row #(
        .WIDTH   (ACC_W)
    ) u_row (
        .a_i     (s_q),
        .b_i     (c_q),
        .c_i     (operand),
        .sum_o   (row_sum),
        .carry_o (row_carry)
    );

    // Single carry-propagate add, optionally clamped when the group overflowed
`ifdef CSA_ACC_SAT_EN
    assign resolved = ovf_q ? {ACC_W{1'b1}} : (s_q + c_q);
`else
    assign resolved = s_q + c_q;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath next values and handshake outputs
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        count_d   = count_q;
        oovf_d    = oovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    s_d     = row_sum;
                    c_d     = row_carry;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = in_last ? RESOLVE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    s_d = row_sum;
                    c_d = row_carry;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q >= CNT_LIMIT) begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                sum_d   = resolved;
                count_d = cnt_q;
                oovf_d  = ovf_q;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Redundant accumulator, counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            oovf_q  <= 1'b0;
        end else begin
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            oovf_q  <= oovf_d;
        end
    end

    assign out_sum   = sum_q;
    assign out_count = count_q;
    assign out_ovf   = oovf_q;

endmodule : csa_accum_ctrl
`default_nettype wire

// File: tb/tb_csa_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csa_accum_ctrl
//  Description : Self-checking bench for csa_accum_ctrl: directed groups plus
//                randomized groups checked against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_csa_accum_ctrl;

    localparam int DATA_W  = 16;
    localparam int GUARD_W = 4;
    localparam int ACC_W   = DATA_W + GUARD_W;
    localparam int CNT_W   = GUARD_W + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    csa_accum_ctrl #(
        .DATA_W    (DATA_W),
        .GUARD_W   (GUARD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer sum of the group, reduced modulo 2**ACC_W
    function automatic void model(input logic [15:0] ops[$],
                                  output logic [ACC_W-1:0] es,
                                  output logic [CNT_W-1:0] ec,
                                  output logic eo);
        longint total = 0;
        int     n     = ops.size();
        foreach (ops[i]) total += longint'(ops[i]);
        es = ACC_W'(total);
        eo = (n > (1 << GUARD_W));
        ec = (n > 31) ? CNT_W'(31) : CNT_W'(n);
`ifdef CSA_ACC_SAT_EN
        if (eo) es = {ACC_W{1'b1}};
`endif
    endfunction

    // Inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand after an optional gap of invalid cycles with junk in_last
    task automatic put(input logic [15:0] d, input bit last, input int gap);
        int w = 0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            step();
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the last beat's accepting edge; checks latency,
    // result, hold behaviour with a busy source, and return to IDLE
    task automatic collect(input logic [15:0] ops[$], input int stall);
        logic [ACC_W-1:0] es;
        logic [CNT_W-1:0] ec;
        logic             eo;
        int               w = 0;
        model(ops, es, ec, eo);
        chk("resolve_valid", 64'(out_valid), 64'd0);
        chk("resolve_in_ready", 64'(in_ready), 64'd0);
        while (!out_valid && w < 50) begin
            step();
            w++;
        end
        chk("latency", 64'(w), 64'd1);
        chk("out_sum", 64'(out_sum), 64'(es));
        chk("out_count", 64'(out_count), 64'(ec));
        chk("out_ovf", 64'(out_ovf), 64'(eo));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'($urandom);
        in_last   = 1'($urandom_range(0, 1));
        for (int i = 0; i < stall; i++) begin
            step();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_sum", 64'(out_sum), 64'(es));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_busy", 64'(busy), 64'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_busy", 64'(busy), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic run_group(input logic [15:0] ops[$], input int gapmax, input int stall);
        for (int i = 0; i < ops.size(); i++) begin
            put(ops[i], (i == ops.size() - 1), $urandom_range(0, gapmax));
        end
        collect(ops, stall);
    endtask

    logic [15:0] q[$];
    int          n;
    bit          allones;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        rst = 1'b0;
        step();

        // Single operand
        q = '{16'h1234};
        run_group(q, 0, 0);

        // Three all-ones back-to-back
        q = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
        run_group(q, 0, 0);

        // Sixteen and seventeen all-ones: edge of the guard headroom
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(16'hFFFF);
        run_group(q, 0, 1);
        q.push_back(16'hFFFF);
        run_group(q, 0, 1);

        // Long DONE stall with a pending source, then a small group
        q = '{16'h00AA};
        run_group(q, 0, 5);
        q = '{16'h0001, 16'h0002};
        run_group(q, 0, 0);

        // Asynchronous reset in the middle of a group
        put(16'h00AA, 1'b0, 0);
        put(16'h0055, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_sum", 64'(out_sum), 64'd0);
        chk("midrst_out_count", 64'(out_count), 64'd0);
        chk("midrst_out_ovf", 64'(out_ovf), 64'd0);
        step();
        rst = 1'b0;
        q = '{16'h0010};
        run_group(q, 0, 0);

        // Randomized groups, including counter saturation past 31 operands
        for (int g = 0; g < 40; g++) begin
            n       = (g == 0) ? 35 : $urandom_range(1, 20);
            allones = ($urandom_range(0, 3) == 0);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(allones ? 16'hFFFF : 16'($urandom));
            run_group(q, 2, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_csa_accum_ctrl
`default_nettype wire

// File: doc/csa_accum_ctrl.md
Name: csa_accum_ctrl

Overview:
- Sequencer for multi-operand addition built around a 3:2 carry-save row.
- Accepts a stream of DATA_W-bit operands over a valid/ready handshake and compresses each into redundant sum/carry registers, one operand per cycle.
- On the last operand it performs a single carry-propagate resolve and presents the binary result on an output handshake.
- Sits between an operand source, such as a partial-product or sample stream, and any consumer of the packed sum.

Parameters:
- DATA_W, 16, operand width.
- GUARD_W, 4, guard bits; overflow-free for up to 2**GUARD_W operands. ACC_W = DATA_W+GUARD_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  operand accepted when in_valid & in_ready.
- in_data  input  DATA_W  operand, zero-extended to ACC_W.
- in_last  input  1  marks final operand of a group.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  ACC_W  resolved sum.
- out_count  output  GUARD_W+1  operands in the group, saturating at all-ones.
- out_ovf  output  1  more than 2**GUARD_W operands were accepted.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; S_reg, C_reg, out_sum, out_count all 0; out_ovf=0; out_valid=0; in_ready=1.
- Compression per accepted beat, with x = zero-extended in_data:
  - S' = S ^ C ^ x.
  - C' = (maj(S,C,x) << 1) truncated to ACC_W.
  - C_reg always holds carries already at their final weight.
  - Invariant: S+C ≡ sum of accepted operands (mod 2**ACC_W).
- States:
  - IDLE:
    - in_ready=1.
    - On accept: compress, cnt=1.
    - Next state: RESOLVE if in_last, else ACCUM.
  - ACCUM:
    - in_ready=1.
    - Each accept: compress, cnt++ (saturating).
    - If cnt is already 2**GUARD_W on an accept, set sticky ovf.
    - in_last on an accepted beat → RESOLVE.
    - No accept → hold.
  - RESOLVE:
    - in_ready=0, one cycle.
    - out_sum <= S+C (mod 2**ACC_W); out_count <= cnt; out_ovf <= ovf.
    - → DONE.
  - DONE:
    - out_valid=1, in_ready=0.
    - out_sum, out_count and out_ovf are stable until out_ready.
    - On out_ready: clear S, C, cnt, ovf; out_valid=0 next cycle; → IDLE.
- Latency: last beat accepted at cycle t → out_valid high at t+2. Throughput: one group per N+2 cycles minimum.
- in_last is ignored when in_valid=0. in_valid while in_ready=0 is not consumed; the source must hold its data.
- out_ready while out_valid=0 is ignored.
- No new group is accepted in the same cycle as the output handshake; IDLE is re-entered first.
- Overflow wraps modulo 2**ACC_W; out_ovf flags it.

Optional Feature:
- Macro: CSA_ACC_SAT_EN.
- Defined: if ovf is set at RESOLVE, out_sum = all-ones (2**ACC_W-1).
- Undefined: out_sum wraps modulo 2**ACC_W. out_ovf is reported identically in both builds.

Decomposition:
- Package csa_accum_pkg:
  - state enum (IDLE, ACCUM, RESOLVE, DONE), 2-bit encoding.
  - ACC_W and count-width derivation functions.
- Sub-module csa_row:
  - parameterised WIDTH, purely combinational 3:2 compressor row.
  - outputs: s, and carry pre-shifted/truncated.
  - instantiated once at ACC_W.

Test Plan (DATA_W=16, GUARD_W=4, ACC_W=20):
- Single 0x1234 with in_last → out_sum=0x01234, out_count=1, out_ovf=0, out_valid exactly 2 cycles after accept.
- Three 0xFFFF, back-to-back, last on third → out_sum=0x2FFFD, out_count=3.
- Sixteen 0xFFFF → out_sum=0xFFFF0, out_count=16, out_ovf=0.
- Seventeen 0xFFFF → out_ovf=1, out_count=17; out_sum=0x0FFEF without CSA_ACC_SAT_EN, 0xFFFFF with it.
- DONE with out_ready low for 5 cycles while in_valid=1 → in_ready=0, out_sum stable, no operand consumed; out_ready=1 → IDLE; next group 0x0001,0x0002(last) → out_sum=0x00003.
- rst pulsed mid-ACCUM after 0x00AA, 0x0055 → all outputs reset immediately; next group 0x0010(last) → out_sum=0x00010 (no residue).
